// File: rtl/rv32i_types.sv
// Shared sizing for the rename free list: physical/architectural register counts and pointer widths.
package rv32i_types;
    localparam int PR_NUM   = 64;
    localparam int RRF_NUM  = 32;
    localparam int PR_WIDTH = $clog2(PR_NUM);
    localparam int FL_DEPTH = PR_NUM - RRF_NUM;
    localparam int PTR_W    = $clog2(FL_DEPTH) + 1;

    typedef logic [PR_WIDTH-1:0] pr_t;
    typedef logic [PTR_W-1:0]    fl_ptr_t;
endpackage

// File: rtl/free_list.sv
// Circular free list of physical register indices with speculative head and committed-head rewind.
// Optional double-free tracking is compiled in with `define FREELIST_CHECK_EN.
module free_list
    import rv32i_types::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_req,
    output logic [PR_WIDTH-1:0] alloc_pd,
    output logic                alloc_valid,
    input  logic                commit_alloc,
    input  logic                free_we,
    input  logic [PR_WIDTH-1:0] free_pd,
    input  logic                flush,
    output logic [PTR_W-1:0]    free_count,
    output logic                dbl_free_err
);
    localparam int IDX_W = PTR_W - 1;

    pr_t     mem_q [FL_DEPTH];
    fl_ptr_t head_q, head_d;
    fl_ptr_t tail_q, tail_d;
    fl_ptr_t cmt_head_q, cmt_head_d;
    fl_ptr_t rewind_ptr;
    logic    empty, full, pop, push, dbl_hit;

    assign empty       = (head_q == tail_q);
    assign full        = (head_q[PTR_W-1] != tail_q[PTR_W-1]) &&
                         (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]);
    assign alloc_pd    = mem_q[head_q[IDX_W-1:0]];
    assign alloc_valid = !empty;
    assign free_count  = tail_q - head_q;
    assign pop         = alloc_req && !empty && !flush;
    assign push        = free_we && !full && !dbl_hit;
    // A same-cycle commit retires the oldest speculative entry before the rewind.
    assign rewind_ptr  = cmt_head_q + PTR_W'(commit_alloc);

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        cmt_head_d = rewind_ptr;
        if (flush)
            head_d = rewind_ptr;
        else if (pop)
            head_d = head_q + PTR_W'(1);
        if (push)
            tail_d = tail_q + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            cmt_head_q <= '0;
            tail_q     <= PTR_W'(FL_DEPTH);
        end else begin
            head_q     <= head_d;
            cmt_head_q <= cmt_head_d;
            tail_q     <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++)
                mem_q[i] <= PR_WIDTH'(RRF_NUM + i);
        end else if (push) begin
            mem_q[tail_q[IDX_W-1:0]] <= free_pd;
        end
    end

`ifdef FREELIST_CHECK_EN
    logic [PR_NUM-1:0] in_list_q, in_list_d;
    fl_ptr_t           rewind_cnt;
    logic [IDX_W-1:0]  rewind_slot;
    logic              dbl_err_q;

    assign dbl_hit    = free_we && in_list_q[free_pd];
    assign rewind_cnt = head_q - rewind_ptr;

    always_comb begin
        in_list_d   = in_list_q;
        rewind_slot = '0;
        if (pop)
            in_list_d[alloc_pd] = 1'b0;
        // Speculatively popped slots that the flush hands back become free again.
        if (flush) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                rewind_slot = rewind_ptr[IDX_W-1:0] + IDX_W'(i);
                if (PTR_W'(i) < rewind_cnt)
                    in_list_d[mem_q[rewind_slot]] = 1'b1;
            end
        end
        if (push)
            in_list_d[free_pd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_list_q <= {{FL_DEPTH{1'b1}}, {RRF_NUM{1'b0}}};
            dbl_err_q <= 1'b0;
        end else begin
            in_list_q <= in_list_d;
            if (dbl_hit)
                dbl_err_q <= 1'b1;
        end
    end

    assign dbl_free_err = dbl_err_q;
`else
    assign dbl_hit      = 1'b0;
    assign dbl_free_err = 1'b0;
`endif

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(free_we && full));

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: a queue model of free entries plus an in-flight queue for flush rewind.
module tb_free_list;
    import rv32i_types::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                alloc_req = 1'b0;
    logic                commit_alloc = 1'b0;
    logic                free_we = 1'b0;
    logic                flush = 1'b0;
    logic [PR_WIDTH-1:0] free_pd = '0;
    logic [PR_WIDTH-1:0] alloc_pd;
    logic                alloc_valid;
    logic [PTR_W-1:0]    free_count;
    logic                dbl_free_err;

    int checks = 0;
    int errors = 0;

    logic [PR_WIDTH-1:0] fl_q[$];
    logic [PR_WIDTH-1:0] inflight_q[$];
    bit                  err_m;

    always #5 clk = ~clk;

    free_list dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_pd     (alloc_pd),
        .alloc_valid  (alloc_valid),
        .commit_alloc (commit_alloc),
        .free_we      (free_we),
        .free_pd      (free_pd),
        .flush        (flush),
        .free_count   (free_count),
        .dbl_free_err (dbl_free_err)
    );

    task automatic model_reset();
        fl_q.delete();
        inflight_q.delete();
        for (int i = 0; i < FL_DEPTH; i++)
            fl_q.push_back(PR_WIDTH'(RRF_NUM + i));
        err_m = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; alloc_req = 0; commit_alloc = 0; free_we = 0; flush = 0; free_pd = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // One clock of stimulus: compares outputs against the model before the edge, then advances the model.
    task automatic cycle(input bit req, input bit cmt, input bit we,
                         input logic [PR_WIDTH-1:0] pd, input bit fl);
        bit dbl;
        bit was_full;
        bit do_pop;
        dbl      = 1'b0;
        was_full = (fl_q.size() == FL_DEPTH);
        do_pop   = req && !fl && (fl_q.size() != 0);
        alloc_req = req; commit_alloc = cmt; free_we = we; free_pd = pd; flush = fl;
        #1;
        checks++;
        if (alloc_valid !== (fl_q.size() != 0)) begin
            errors++;
            $display("FAIL alloc_valid: got %b want %b", alloc_valid, fl_q.size() != 0);
        end
        checks++;
        if (free_count !== PTR_W'(fl_q.size())) begin
            errors++;
            $display("FAIL free_count: got %0d want %0d", free_count, fl_q.size());
        end
        checks++;
        if (dbl_free_err !== err_m) begin
            errors++;
            $display("FAIL dbl_free_err: got %b want %b", dbl_free_err, err_m);
        end
        if (do_pop) begin
            checks++;
            if (alloc_pd !== fl_q[0]) begin
                errors++;
                $display("FAIL alloc_pd: got %0d want %0d", alloc_pd, fl_q[0]);
            end
        end
`ifdef FREELIST_CHECK_EN
        if (we) foreach (fl_q[k]) if (fl_q[k] == pd) dbl = 1'b1;
`endif
        if (do_pop) inflight_q.push_back(fl_q.pop_front());
        if (cmt && inflight_q.size() != 0) void'(inflight_q.pop_front());
        if (fl) begin
            for (int k = inflight_q.size() - 1; k >= 0; k--)
                fl_q.push_front(inflight_q[k]);
            inflight_q.delete();
        end
        if (we) begin
            if (dbl) err_m = 1'b1;
            else if (!was_full) fl_q.push_back(pd);
        end
        @(posedge clk);
        #1;
        alloc_req = 0; commit_alloc = 0; free_we = 0; flush = 0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (fl_q.size() != 0 && budget < 40) begin
            cycle(1, 0, 0, '0, 0);
            budget++;
        end
        checks++;
        if (fl_q.size() != 0 || alloc_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_bound: got valid=%b model_left=%0d want empty", alloc_valid, fl_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (alloc_valid !== 1'b1 || alloc_pd !== 6'd32 || free_count !== 6'd32 || dbl_free_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b pd=%0d cnt=%0d err=%b want 1 32 32 0",
                     alloc_valid, alloc_pd, free_count, dbl_free_err);
        end
    endtask

    task automatic test_drain_and_push_empty();
        do_reset();
        drain();
        checks++;
        if (free_count !== 6'd0) begin
            errors++;
            $display("FAIL drained_count: got %0d want 0", free_count);
        end
        cycle(1, 0, 0, '0, 0);
        cycle(0, 0, 1, 6'd40, 0);
        checks++;
        if (alloc_valid !== 1'b1 || alloc_pd !== 6'd40) begin
            errors++;
            $display("FAIL push_after_empty: got v=%b pd=%0d want 1 40", alloc_valid, alloc_pd);
        end
        cycle(1, 0, 0, '0, 0);
    endtask

    task automatic test_flush_rewind();
        do_reset();
        repeat (5) cycle(1, 0, 0, '0, 0);
        cycle(0, 1, 1, 6'd1, 0);
        cycle(0, 1, 1, 6'd2, 0);
        cycle(0, 0, 0, '0, 1);
        checks++;
        if (alloc_pd !== 6'd34 || free_count !== 6'd32) begin
            errors++;
            $display("FAIL flush_rewind: got pd=%0d cnt=%0d want 34 32", alloc_pd, free_count);
        end
        drain();
    endtask

    task automatic test_pop_push_same_cycle();
        do_reset();
        repeat (22) cycle(1, 0, 0, '0, 0);
        cycle(1, 0, 1, 6'd5, 0);
        checks++;
        if (free_count !== 6'd10) begin
            errors++;
            $display("FAIL pop_push_count: got %0d want 10", free_count);
        end
        drain();
    endtask

    task automatic test_flush_commit_push();
        do_reset();
        repeat (3) cycle(1, 0, 0, '0, 0);
        cycle(1, 1, 1, 6'd7, 1);
        checks++;
        if (alloc_pd !== 6'd33 || free_count !== 6'd32) begin
            errors++;
            $display("FAIL flush_commit_push: got pd=%0d cnt=%0d want 33 32", alloc_pd, free_count);
        end
        drain();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        repeat (4) cycle(1, 0, 0, '0, 0);
        rst = 1'b1; flush = 1'b1; free_we = 1'b1; free_pd = 6'd9; alloc_req = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; flush = 0; free_we = 0; alloc_req = 0;
        model_reset();
        checks++;
        if (alloc_valid !== 1'b1 || alloc_pd !== 6'd32 || free_count !== 6'd32) begin
            errors++;
            $display("FAIL reset_mid_op: got v=%b pd=%0d cnt=%0d want 1 32 32",
                     alloc_valid, alloc_pd, free_count);
        end
        repeat (3) cycle(1, 0, 0, '0, 0);
    endtask

    task automatic test_dbl_free();
`ifdef FREELIST_CHECK_EN
        do_reset();
        cycle(1, 0, 0, '0, 0);
        cycle(0, 0, 1, 6'd50, 0);
        checks++;
        if (dbl_free_err !== 1'b1 || free_count !== 6'd31) begin
            errors++;
            $display("FAIL dbl_free: got err=%b cnt=%0d want 1 31", dbl_free_err, free_count);
        end
        repeat (2) cycle(1, 0, 0, '0, 0);
        do_reset();
        cycle(0, 0, 0, '0, 0);
`endif
    endtask

    initial begin
        test_reset();
        test_drain_and_push_empty();
        test_flush_rewind();
        test_pop_push_same_cycle();
        test_flush_commit_push();
        test_reset_mid_op();
        test_dbl_free();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
